// File: rtl/spinnaker_fpgas_ctrl_regs.sv
// Control/diagnostic register bank for the SpiNNaker FPGA designs:
// peripheral MC key/mask pairs, saturating event counters, sticky status with IRQ.
module spinnaker_fpgas_ctrl_regs #(
  parameter int unsigned REGA_BITS  = 14,
  parameter int unsigned REGD_BITS  = 32,
  parameter int unsigned FLAG_BITS  = 8,
  parameter int unsigned NUM_PERIPH = 4,
  parameter int unsigned NUM_CNT    = 4,
  parameter int unsigned CNT_BITS   = 32,
  parameter int unsigned STAT_BITS  = 8
) (
  input  logic                     CLK_IN,
  input  logic                     RESET_IN,
  input  logic                     WRITE_IN,
  input  logic                     READ_IN,
  input  logic [REGA_BITS-1:0]     ADDR_IN,
  input  logic [REGD_BITS-1:0]     WRITE_DATA_IN,
  output logic [REGD_BITS-1:0]     READ_DATA_OUT,
  output logic                     READ_VALID_OUT,
  input  logic [REGD_BITS-1:0]     VERSION_IN,
  input  logic [FLAG_BITS-1:0]     FLAGS_IN,
  input  logic [STAT_BITS-1:0]     STATUS_IN,
  input  logic [NUM_CNT-1:0]       EVENT_IN,
  output logic [32*NUM_PERIPH-1:0] PERIPH_MC_KEY_OUT,
  output logic [32*NUM_PERIPH-1:0] PERIPH_MC_MASK_OUT,
  output logic                     IRQ_OUT
);

  localparam int unsigned ADR_VERS    = 0;
  localparam int unsigned ADR_FLAG    = 1;
  localparam int unsigned ADR_SCRATCH = 2;
  localparam int unsigned ADR_CTRL    = 3;
  localparam int unsigned ADR_STICKY  = 4;
  localparam int unsigned ADR_CNT     = 8;
  localparam int unsigned ADR_PERIPH  = 16;
  localparam int unsigned IRQ_EN_LSB  = 8;

  logic [REGD_BITS-1:0] scratch_q;
  logic                 freeze_q;
  logic                 cor_q;
  logic [STAT_BITS-1:0] irq_en_q;
  logic [STAT_BITS-1:0] sticky_q;
  logic [CNT_BITS-1:0]  cnt_q  [NUM_CNT];
  logic [31:0]          key_q  [NUM_PERIPH];
  logic [31:0]          mask_q [NUM_PERIPH];

  logic [REGD_BITS-1:0]  rd_data_c;
  logic [REGD_BITS-1:0]  ctrl_c;
  logic [STAT_BITS-1:0]  w1c_c;
  logic [NUM_CNT-1:0]    cnt_hit_c;
  logic [NUM_CNT-1:0]    ev_c;
  logic [NUM_PERIPH-1:0] key_hit_c;
  logic [NUM_PERIPH-1:0] mask_hit_c;

  // Address decode and read mux; unmapped addresses read as all ones
  always_comb begin
    ctrl_c                         = '0;
    ctrl_c[0]                      = freeze_q;
    ctrl_c[1]                      = cor_q;
    ctrl_c[IRQ_EN_LSB +: STAT_BITS] = irq_en_q;
    cnt_hit_c  = '0;
    key_hit_c  = '0;
    mask_hit_c = '0;
    rd_data_c  = '1;
    case (ADDR_IN)
      REGA_BITS'(ADR_VERS):    rd_data_c = VERSION_IN;
      REGA_BITS'(ADR_FLAG):    rd_data_c = REGD_BITS'(FLAGS_IN);
      REGA_BITS'(ADR_SCRATCH): rd_data_c = scratch_q;
      REGA_BITS'(ADR_CTRL):    rd_data_c = ctrl_c;
      REGA_BITS'(ADR_STICKY):  rd_data_c = REGD_BITS'(sticky_q);
      default: ;
    endcase
    for (int c = 0; c < NUM_CNT; c++) begin
      if (ADDR_IN == REGA_BITS'(ADR_CNT + c)) begin
        cnt_hit_c[c] = 1'b1;
        rd_data_c    = REGD_BITS'(cnt_q[c]);
      end
    end
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (ADDR_IN == REGA_BITS'(ADR_PERIPH + 2 * i)) begin
        key_hit_c[i] = 1'b1;
        rd_data_c    = REGD_BITS'(key_q[i]);
      end
      if (ADDR_IN == REGA_BITS'(ADR_PERIPH + 2 * i + 1)) begin
        mask_hit_c[i] = 1'b1;
        rd_data_c     = REGD_BITS'(mask_q[i]);
      end
    end
  end

  assign w1c_c = (WRITE_IN && ADDR_IN == REGA_BITS'(ADR_STICKY)) ?
                 WRITE_DATA_IN[STAT_BITS-1:0] : '0;
  assign ev_c  = EVENT_IN & {NUM_CNT{~freeze_q}};

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      scratch_q      <= '0;
      freeze_q       <= 1'b0;
      cor_q          <= 1'b0;
      irq_en_q       <= '0;
      sticky_q       <= '0;
      READ_DATA_OUT  <= '0;
      READ_VALID_OUT <= 1'b0;
      IRQ_OUT        <= 1'b0;
      for (int c = 0; c < NUM_CNT; c++) cnt_q[c] <= '0;
      for (int i = 0; i < NUM_PERIPH; i++) begin
        key_q[i]  <= '1;
        mask_q[i] <= '0;
      end
    end else begin
      READ_VALID_OUT <= READ_IN;
      if (READ_IN) READ_DATA_OUT <= rd_data_c;

      if (WRITE_IN && ADDR_IN == REGA_BITS'(ADR_SCRATCH)) scratch_q <= WRITE_DATA_IN;
      if (WRITE_IN && ADDR_IN == REGA_BITS'(ADR_CTRL)) begin
        freeze_q <= WRITE_DATA_IN[0];
        cor_q    <= WRITE_DATA_IN[1];
        irq_en_q <= WRITE_DATA_IN[IRQ_EN_LSB +: STAT_BITS];
      end

      // Set beats clear: STATUS_IN is ORed in after the W1C mask
      sticky_q <= (sticky_q & ~w1c_c) | STATUS_IN;
      IRQ_OUT  <= |(sticky_q & irq_en_q);

      // Write clear has priority; clear-on-read keeps a coincident event
      for (int c = 0; c < NUM_CNT; c++) begin
        if (WRITE_IN && cnt_hit_c[c])
          cnt_q[c] <= '0;
        else if (READ_IN && cor_q && cnt_hit_c[c])
          cnt_q[c] <= CNT_BITS'(ev_c[c]);
        else if (ev_c[c] && cnt_q[c] != '1)
          cnt_q[c] <= cnt_q[c] + CNT_BITS'(1);
      end

      for (int i = 0; i < NUM_PERIPH; i++) begin
        if (WRITE_IN && key_hit_c[i])  key_q[i]  <= WRITE_DATA_IN[31:0];
        if (WRITE_IN && mask_hit_c[i]) mask_q[i] <= WRITE_DATA_IN[31:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_PERIPH; g++) begin : g_periph
    assign PERIPH_MC_KEY_OUT[32*g +: 32]  = key_q[g];
    assign PERIPH_MC_MASK_OUT[32*g +: 32] = mask_q[g];
  end

endmodule

// File: tb/tb_spinnaker_fpgas_ctrl_regs.sv
// Directed bench for spinnaker_fpgas_ctrl_regs; expected read data is queued
// at issue and checked when READ_VALID_OUT appears.
module tb_spinnaker_fpgas_ctrl_regs;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr;
  logic         rd;
  logic [13:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  version;
  logic [7:0]   flags;
  logic [7:0]   status;
  logic [3:0]   event_a;
  logic [3:0]   event_b;
  logic [31:0]  rdata_a, rdata_b;
  logic         rvalid_a, rvalid_b;
  logic [127:0] key_a, mask_a, key_b, mask_b;
  logic         irq_a, irq_b;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  spinnaker_fpgas_ctrl_regs u_dut (
    .CLK_IN(clk), .RESET_IN(reset), .WRITE_IN(wr), .READ_IN(rd),
    .ADDR_IN(addr), .WRITE_DATA_IN(wdata), .READ_DATA_OUT(rdata_a),
    .READ_VALID_OUT(rvalid_a), .VERSION_IN(version), .FLAGS_IN(flags),
    .STATUS_IN(status), .EVENT_IN(event_a), .PERIPH_MC_KEY_OUT(key_a),
    .PERIPH_MC_MASK_OUT(mask_a), .IRQ_OUT(irq_a)
  );

  // Narrow-counter instance so saturation is reachable in a few events
  spinnaker_fpgas_ctrl_regs #(.CNT_BITS(4)) u_sat (
    .CLK_IN(clk), .RESET_IN(reset), .WRITE_IN(wr), .READ_IN(rd),
    .ADDR_IN(addr), .WRITE_DATA_IN(wdata), .READ_DATA_OUT(rdata_b),
    .READ_VALID_OUT(rvalid_b), .VERSION_IN(version), .FLAGS_IN(flags),
    .STATUS_IN(status), .EVENT_IN(event_b), .PERIPH_MC_KEY_OUT(key_b),
    .PERIPH_MC_MASK_OUT(mask_b), .IRQ_OUT(irq_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [13:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  // Issue a read; the pulse must show exactly one edge later
  task automatic rd_reg(input logic [13:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    rd = 1'b1; addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    rd = 1'b0;
    check({tag, "_valid"}, 128'(rvalid_a), 128'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (rvalid_a) check(t, 128'(rdata_a), 128'(e));
    end
  endtask

  task automatic pulse(input int idx, input int n, input bit narrow);
    for (int k = 0; k < n; k++) begin
      if (narrow) event_b = 4'(1 << idx); else event_a = 4'(1 << idx);
      tick();
      event_a = '0; event_b = '0;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b1; addr = 14'd2; wdata = '0;
    version = 32'hA5A5_0102; flags = 8'h5C; status = '0;
    event_a = '0; event_b = '0;

    // Reset state; a read during reset must not pulse
    tick(); tick();
    check("rst_valid", 128'(rvalid_a), 128'(0));
    check("rst_rdata", 128'(rdata_a), 128'(0));
    check("rst_irq", 128'(irq_a), 128'(0));
    check("rst_key", key_a, {128{1'b1}});
    check("rst_mask", mask_a, 128'(0));
    check("rst_key_b", key_b, {128{1'b1}});
    check("rst_mask_b", mask_b, 128'(0));
    check("rst_irq_b", 128'(irq_b), 128'(0));
    reset = 1'b0; rd = 1'b0;
    tick();

    // Plain reads, unmapped, and hold between reads
    rd_reg(14'd2, 32'h0, "scratch_rst");
    rd_reg(14'd16, 32'hFFFF_FFFF, "key0_rst");
    rd_reg(14'd17, 32'h0, "mask0_rst");
    rd_reg(14'h30, 32'hFFFF_FFFF, "unmapped");
    tick();
    check("valid_one_cycle", 128'(rvalid_a), 128'(0));
    check("rdata_hold", 128'(rdata_a), 128'(32'hFFFF_FFFF));
    rd_reg(14'd0, 32'hA5A5_0102, "vers");
    rd_reg(14'd1, 32'h0000_005C, "flag");
    wr_reg(14'd2, 32'hCAFE_F00D);
    rd_reg(14'd2, 32'hCAFE_F00D, "scratch_wr");
    wr_reg(14'd0, 32'h1234_5678);
    rd_reg(14'd0, 32'hA5A5_0102, "vers_ro");

    // Read and write same address in one cycle returns the old value
    wr = 1'b1; wdata = 32'h0BAD_0BAD;
    rd_reg(14'd2, 32'hCAFE_F00D, "rw_same_cycle");
    wr = 1'b0;
    rd_reg(14'd2, 32'h0BAD_0BAD, "rw_after");

    // Peripheral pair 3
    wr_reg(14'd22, 32'h1234_0000);
    check("key3_out", 128'(key_a[127:96]), 128'(32'h1234_0000));
    wr_reg(14'd23, 32'hFFFF_0000);
    check("mask3_out", 128'(mask_a[127:96]), 128'(32'hFFFF_0000));
    check("key_others", 128'(key_a[95:0]), {32'h0, {96{1'b1}}});
    check("mask_others", 128'(mask_a[95:0]), 128'(0));
    rd_reg(14'd22, 32'h1234_0000, "key3_rd");

    // Counter 1: count, clear-on-read with coincident event, freeze
    pulse(1, 5, 1'b0);
    rd_reg(14'd9, 32'd5, "cnt1_5");
    wr_reg(14'd3, 32'h2);
    event_a = 4'b0010;
    rd_reg(14'd9, 32'd5, "cnt1_cor");
    event_a = '0;
    rd_reg(14'd9, 32'd1, "cnt1_cor_event_kept");
    wr_reg(14'd3, 32'h0);
    pulse(1, 2, 1'b0);
    rd_reg(14'd9, 32'd2, "cnt1_no_cor");
    wr_reg(14'd3, 32'h1);
    rd_reg(14'd3, 32'h1, "ctrl_rd");
    pulse(1, 3, 1'b0);
    rd_reg(14'd9, 32'd2, "cnt1_frozen");
    wr_reg(14'd3, 32'h0);

    // Saturation on the narrow instance, write-wins on the wide one
    pulse(0, 18, 1'b1);
    rd_reg(14'd8, 32'd0, "cnt0_idle");
    check("sat_valid", 128'(rvalid_b), 128'(1));
    check("sat_value", 128'(rdata_b), 128'(32'h0000_000F));
    pulse(0, 3, 1'b0);
    rd_reg(14'd8, 32'd3, "cnt0_3");
    event_a = 4'b0001;
    wr_reg(14'd8, 32'h0);
    event_a = '0;
    rd_reg(14'd8, 32'd0, "cnt0_write_wins");

    // Sticky status and interrupt
    wr_reg(14'd3, 32'h400);
    status = 8'h04;
    tick();
    status = '0;
    check("irq_lag", 128'(irq_a), 128'(0));
    tick();
    check("irq_rise", 128'(irq_a), 128'(1));
    rd_reg(14'd4, 32'h4, "sticky_set");
    wr_reg(14'd4, 32'h4);
    check("irq_still", 128'(irq_a), 128'(1));
    rd_reg(14'd4, 32'h0, "sticky_clr");
    check("irq_fall", 128'(irq_a), 128'(0));
    status = 8'h04;
    wr_reg(14'd4, 32'h4);
    status = '0;
    rd_reg(14'd4, 32'h4, "sticky_set_wins");

    // Mid-stream reset with a read in flight
    wr_reg(14'd16, 32'hDEAD_BEEF);
    pulse(2, 2, 1'b0);
    check("key0_pre", 128'(key_a[31:0]), 128'(32'hDEAD_BEEF));
    reset = 1'b1; rd = 1'b1; addr = 14'd16;
    tick();
    reset = 1'b0; rd = 1'b0;
    check("rst2_valid", 128'(rvalid_a), 128'(0));
    check("rst2_rdata", 128'(rdata_a), 128'(0));
    check("rst2_key", key_a, {128{1'b1}});
    check("rst2_mask", mask_a, 128'(0));
    check("rst2_irq", 128'(irq_a), 128'(0));
    rd_reg(14'd10, 32'd0, "rst2_cnt2");
    rd_reg(14'd2, 32'd0, "rst2_scratch");
    rd_reg(14'd3, 32'd0, "rst2_ctrl");
    rd_reg(14'd4, 32'd0, "rst2_sticky");
    check("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
